demux1t2_8_buf: RTL and testbench

Buffered 1-to-2 byte demultiplexer: the receive-side counterpart of the 8-bit 2-to-1 select path in the ALU datapath. One shared 8-bit valid/ready stream enters with a per-byte select bit, and each byte is steered into one of two output channels. Each channel has its own small FIFO and a delivered-byte counter, so a stalled consumer on one channel never corrupts the other channel's data. The block sits between the CPU-side byte bus and the two peripheral consumers: game-logic channel 0 and display channel 1.

---
 rtl/demux1t2_8_buf_pkg.sv | 16 +
 rtl/demux1t2_8_buf_if.sv | 34 +++
 rtl/demux1t2_8_buf_byte_fifo.sv | 59 +++++
 rtl/demux1t2_8_buf.sv | 137 +++++++++++++
 tb/tb_demux1t2_8_buf.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux1t2_8_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 byte demultiplexer:
// default FIFO geometry, channel indices and small arithmetic helpers.
package demux1t2_8_buf_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 2;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Delivered-byte counter step; wraps modulo 256 by construction.
    function automatic logic [7:0] cnt_inc(input logic [7:0] c);
        return c + 8'd1;
    endfunction

endpackage

// File: rtl/demux1t2_8_buf_if.sv
// Byte-stream bundle between the CPU-side producer, the demultiplexer
// and the two peripheral consumers (channel 0 game logic, channel 1 display).
interface demux1t2_8_buf_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       s;
    logic       in_ready;

    logic       o0_valid;
    logic [7:0] o0_data;
    logic       o0_ready;

    logic       o1_valid;
    logic [7:0] o1_data;
    logic       o1_ready;

    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       ovf_err;

    // Producer / consumer side (drives the input stream and the channel readies).
    modport master (
        output in_valid, in_data, s, o0_ready, o1_ready,
        input  in_ready, o0_valid, o0_data, o1_valid, o1_data, cnt0, cnt1, ovf_err
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, in_data, s, o0_ready, o1_ready,
        output in_ready, o0_valid, o0_data, o1_valid, o1_data, cnt0, cnt1, ovf_err
    );

endinterface

// File: rtl/demux1t2_8_buf_byte_fifo.sv
// 8-bit synchronous FIFO with AW+1-bit pointers. The extra pointer MSB
// distinguishes full from empty when the low bits match. No fall-through:
// a byte pushed into an empty FIFO is visible at dout the next cycle.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [7:0]  mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    // A full FIFO refuses pushes even when it pops in the same cycle.
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset discards all buffered bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write; cleared on reset so the head reads 8'h00 while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/demux1t2_8_buf.sv
// Buffered 1-to-2 byte demultiplexer. Each accepted byte is steered by s
// into its channel FIFO; each channel counts delivered bytes, and a stall
// watchdog flags a producer left waiting on a full channel too long.
module demux1t2_8_buf
    import demux1t2_8_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    demux1t2_8_buf_if.slave  bus
);

    localparam logic [AW:0] STALL_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_TRIP = (AW+1)'(DEPTH - 1);

    logic        full0_s, full1_s;
    logic        empty0_s, empty1_s;
    logic [7:0]  dout0_s, dout1_s;
    logic        in_ready_s;
    logic        push0_s, push1_s;
    logic        pop0_s, pop1_s;
    logic [7:0]  cnt0_r, cnt1_r;
    logic        ovf_r;
    logic        ovf_nxt_s;
    logic [AW:0] stall0_r, stall1_r;
    logic [AW:0] stall0_nxt_s, stall1_nxt_s;
    logic [AW:0] sel_stall_s;

    // Ready depends only on s and the registered full flags, never on o*_ready.
    always_comb begin
        in_ready_s  = 1'b1;
        sel_stall_s = stall0_r;
        case (bus.s)
            CH0: begin
                in_ready_s  = ~full0_s;
                sel_stall_s = stall0_r;
            end
            CH1: begin
                in_ready_s  = ~full1_s;
                sel_stall_s = stall1_r;
            end
            default: begin
                in_ready_s  = 1'b0;
                sel_stall_s = stall0_r;
            end
        endcase
    end

    assign push0_s = bus.in_valid & in_ready_s & (bus.s == CH0);
    assign push1_s = bus.in_valid & in_ready_s & (bus.s == CH1);
    assign pop0_s  = ~empty0_s & bus.o0_ready;
    assign pop1_s  = ~empty1_s & bus.o1_ready;

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0_s),
        .pop   (pop0_s),
        .din   (bus.in_data),
        .dout  (dout0_s),
        .full  (full0_s),
        .empty (empty0_s)
    );

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1_s),
        .pop   (pop1_s),
        .din   (bus.in_data),
        .dout  (dout1_s),
        .full  (full1_s),
        .empty (empty1_s)
    );

    // Stall counters track completed consecutive full cycles, saturating at DEPTH;
    // the watchdog trips when the current cycle is the DEPTH-th full one.
    always_comb begin
        stall0_nxt_s = '0;
        stall1_nxt_s = '0;
        if (full0_s) begin
            stall0_nxt_s = (stall0_r == STALL_MAX) ? stall0_r : stall0_r + (AW+1)'(1);
        end else begin
            stall0_nxt_s = '0;
        end
        if (full1_s) begin
            stall1_nxt_s = (stall1_r == STALL_MAX) ? stall1_r : stall1_r + (AW+1)'(1);
        end else begin
            stall1_nxt_s = '0;
        end
        if (bus.in_valid && !in_ready_s && (sel_stall_s >= STALL_TRIP)) begin
            ovf_nxt_s = 1'b1;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Watchdog state; ovf_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall0_r <= '0;
            stall1_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            stall0_r <= stall0_nxt_s;
            stall1_r <= stall1_nxt_s;
            ovf_r    <= ovf_nxt_s;
        end
    end

    // Delivered-byte counters, one increment per pop, wrapping at 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= 8'h00;
            cnt1_r <= 8'h00;
        end else begin
            if (pop0_s) begin
                cnt0_r <= cnt_inc(cnt0_r);
            end
            if (pop1_s) begin
                cnt1_r <= cnt_inc(cnt1_r);
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.o0_valid = ~empty0_s;
    assign bus.o1_valid = ~empty1_s;
    assign bus.o0_data  = dout0_s;
    assign bus.o1_data  = dout1_s;
    assign bus.cnt0     = cnt0_r;
    assign bus.cnt1     = cnt1_r;
    assign bus.ovf_err  = ovf_r;

endmodule

// File: tb/tb_demux1t2_8_buf.sv
// Scoreboard bench for demux1t2_8_buf: directed scenarios followed by random
// traffic, checked against a queue-based reference model of the two channels.
module tb_demux1t2_8_buf;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    demux1t2_8_buf_if bus ();

    demux1t2_8_buf #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_cnt0 = 8'h00;
    logic [7:0] exp_cnt1 = 8'h00;
    logic       exp_ovf  = 1'b0;
    int         run0 = 0;
    int         run1 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard: compare outputs mid-cycle, then apply the
    // handshakes that will take effect at the next rising edge.
    always @(negedge clk) begin
        logic exp_rdy;
        int   sel_run;
        int   sel_occ;
        if (!rst_n) begin
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_o0_valid", bus.o0_valid, 1'b0);
            chk("rst_o1_valid", bus.o1_valid, 1'b0);
            chk("rst_o0_data",  bus.o0_data,  8'h00);
            chk("rst_o1_data",  bus.o1_data,  8'h00);
            chk("rst_cnt0",     bus.cnt0,     8'h00);
            chk("rst_cnt1",     bus.cnt1,     8'h00);
            chk("rst_ovf",      bus.ovf_err,  1'b0);
            q0.delete();
            q1.delete();
            exp_cnt0 = 8'h00;
            exp_cnt1 = 8'h00;
            exp_ovf  = 1'b0;
            run0 = 0;
            run1 = 0;
        end else begin
            chk("o0_valid", bus.o0_valid, q0.size() != 0);
            chk("o1_valid", bus.o1_valid, q1.size() != 0);
            if (q0.size() != 0) chk("o0_data", bus.o0_data, q0[0]);
            if (q1.size() != 0) chk("o1_data", bus.o1_data, q1[0]);
            chk("cnt0", bus.cnt0, exp_cnt0);
            chk("cnt1", bus.cnt1, exp_cnt1);
            chk("ovf_err", bus.ovf_err, exp_ovf);

            run0 = (q0.size() == DEPTH) ? run0 + 1 : 0;
            run1 = (q1.size() == DEPTH) ? run1 + 1 : 0;
            sel_occ = bus.s ? q1.size() : q0.size();
            sel_run = bus.s ? run1 : run0;
            exp_rdy = (sel_occ < DEPTH);
            chk("in_ready", bus.in_ready, exp_rdy);

            if (bus.in_valid && !exp_rdy && sel_run >= DEPTH) exp_ovf = 1'b1;
            if (q0.size() != 0 && bus.o0_ready) begin
                void'(q0.pop_front());
                exp_cnt0 = exp_cnt0 + 8'd1;
            end
            if (q1.size() != 0 && bus.o1_ready) begin
                void'(q1.pop_front());
                exp_cnt1 = exp_cnt1 + 8'd1;
            end
            if (bus.in_valid && exp_rdy) begin
                if (bus.s) q1.push_back(bus.in_data);
                else       q0.push_back(bus.in_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] d, input logic ch);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.s        = ch;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h on ch %0d not accepted in 20 cycles", d, ch);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.s        = 1'b0;
        bus.o0_ready = 1'b1;
        bus.o1_ready = 1'b1;

        // Reset then idle
        tick(3);
        rst_n = 1'b1;
        tick(3);
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1'b1);
        chk("idle_cnt0", bus.cnt0, 8'h00);

        // Alternating steer
        tick(1);
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        tick(3);
        @(negedge clk);
        chk("alt_cnt0", bus.cnt0, 8'd1);
        chk("alt_cnt1", bus.cnt1, 8'd1);

        // Fill channel 0, refused fifth byte, channel 1 still flows
        tick(1);
        bus.o0_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h14;
        bus.s        = 1'b0;
        @(negedge clk);
        chk("fill_fifth_refused", bus.in_ready, 1'b0);
        tick(2);
        send(8'h55, 1'b1);
        bus.o0_ready = 1'b1;
        tick(8);
        @(negedge clk);
        chk("fill_drain_empty", bus.o0_valid, 1'b0);

        // Counter wrap on channel 1: two bytes already delivered, 254 more reach 256
        tick(1);
        for (int i = 0; i < 254; i++) send(8'(i), 1'b1);
        tick(3);
        @(negedge clk);
        chk("wrap_cnt1_zero", bus.cnt1, 8'd0);
        tick(1);
        send(8'hEE, 1'b1);
        tick(3);
        @(negedge clk);
        chk("wrap_cnt1_one", bus.cnt1, 8'd1);

        // Watchdog: channel 1 held full while the producer keeps offering
        tick(1);
        bus.o1_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b1);
        @(negedge clk);
        chk("wd_before", bus.ovf_err, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hCF;
        bus.s        = 1'b1;
        tick(6);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("wd_set", bus.ovf_err, 1'b1);
        bus.o1_ready = 1'b1;
        tick(8);
        @(negedge clk);
        chk("wd_sticky", bus.ovf_err, 1'b1);

        // Reset mid-operation with two bytes in each FIFO
        tick(1);
        bus.o0_ready = 1'b0;
        bus.o1_ready = 1'b0;
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h31, 1'b1);
        send(8'h32, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o0_valid", bus.o0_valid, 1'b0);
        chk("mid_rst_o1_valid", bus.o1_valid, 1'b0);
        tick(2);
        rst_n = 1'b1;
        bus.o0_ready = 1'b1;
        bus.o1_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_o0_empty", bus.o0_valid, 1'b0);
        chk("post_rst_o1_empty", bus.o1_valid, 1'b0);
        chk("post_rst_ovf", bus.ovf_err, 1'b0);

        // Random traffic against the reference model
        tick(1);
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            bus.s        = 1'($urandom_range(0, 1));
            bus.o0_ready = ($urandom_range(0, 3) != 0);
            bus.o1_ready = ($urandom_range(0, 4) == 0);
            tick(1);
        end
        bus.in_valid = 1'b0;
        bus.o0_ready = 1'b1;
        bus.o1_ready = 1'b1;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
